// File: rtl/dram_init_pkg.sv
// dram_init_pkg: shared state encoding, default phase lengths and helpers for the DRAM init sequencer
package dram_init_pkg;

   typedef enum logic [2:0] {
      RST_HOLD,
      CKE_WAIT,
      TRAIN,
      DONE,
      ERROR
   } state_t;

   localparam int DEF_RESET_CYCLES   = 200;
   localparam int DEF_CKE_CYCLES     = 500;
   localparam int DEF_TIMEOUT_CYCLES = 100000;
   localparam int DEF_MAX_RETRIES    = 3;

   function automatic int max_int(int a, int b);
      return (a > b) ? a : b;
   endfunction

   // Value loaded on the edge that enters a phase, so the phase lasts n cycles (zero behaves as one).
   function automatic int phase_ld(int n);
      return (n > 0) ? n - 1 : 0;
   endfunction

endpackage

// File: rtl/dram_init_timer.sv
// dram_init_timer: loadable down-counter that saturates at zero and flags expiry
module dram_init_timer #(
   parameter int             W       = 8,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] cnt;

   // Load has priority; otherwise count down and hold at zero.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         cnt <= RST_VAL;
      else if (load)
         cnt <= load_val;
      else if (en && cnt != '0)
         cnt <= cnt - 1'b1;

   assign expired = (cnt == '0);

endmodule

// File: rtl/dram_init_seq.sv
// dram_init_seq: DRAM reset/CKE/training sequencer; DRAM_INIT_SEQ_TIMEOUT_EN enables training timeout, retries and ERROR
module dram_init_seq
   import dram_init_pkg::*;
#(
   parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
   parameter int CKE_CYCLES     = DEF_CKE_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
   input  logic       clk_sys,
   input  logic       rst_sys_n,
   input  logic       restart,
   input  logic       dfi_init_complete,
   output logic       dfi_reset_n,
   output logic       dfi_cke,
   output logic       dfi_init_start,
   output logic       init_done,
   output logic       init_error,
   output logic [3:0] retry_cnt
);

`ifdef DRAM_INIT_SEQ_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   localparam int CW = $clog2(max_int(max_int(RESET_CYCLES, CKE_CYCLES), max_int(TIMEOUT_CYCLES, 1)) + 1);
   // The reset interval itself is not counted, so the first hold phase needs one extra count.
   localparam logic [CW-1:0] R_INIT = CW'(max_int(RESET_CYCLES, 1));
   localparam logic [CW-1:0] R_LD   = CW'(phase_ld(RESET_CYCLES));
   localparam logic [CW-1:0] C_LD   = CW'(phase_ld(CKE_CYCLES));
   localparam logic [CW-1:0] T_LD   = CW'(phase_ld(TIMEOUT_CYCLES));

   state_t          state;
   logic            expired;
   logic            timeout;
   logic            retry_ok;
   logic            to_cke;
   logic            to_train;
   logic            to_rst;
   logic [CW-1:0]   ld_val;

   assign retry_ok = retry_cnt < 4'(MAX_RETRIES);
   assign timeout  = TO_EN && state == TRAIN && expired && !dfi_init_complete;
   assign to_cke   = state == RST_HOLD && expired;
   assign to_train = state == CKE_WAIT && expired;
   assign to_rst   = ((state == DONE || state == ERROR) && restart) || (timeout && retry_ok);
   assign ld_val   = to_cke ? C_LD : to_train ? T_LD : R_LD;

   dram_init_timer #(.W(CW), .RST_VAL(R_INIT)) u_timer (
      .clk      (clk_sys),
      .rst_n    (rst_sys_n),
      .load     (to_cke | to_train | to_rst),
      .en       (1'b1),
      .load_val (ld_val),
      .expired  (expired)
   );

   // Sequencer state and registered DFI/status outputs; completion beats timeout in TRAIN.
   always_ff @(posedge clk_sys or negedge rst_sys_n)
      if (!rst_sys_n) begin
         state          <= RST_HOLD;
         dfi_reset_n    <= 1'b0;
         dfi_cke        <= 1'b0;
         dfi_init_start <= 1'b0;
         init_done      <= 1'b0;
         init_error     <= 1'b0;
         retry_cnt      <= 4'd0;
      end else begin
         case (state)
            RST_HOLD:
               if (expired) begin
                  state       <= CKE_WAIT;
                  dfi_reset_n <= 1'b1;
               end
            CKE_WAIT:
               if (expired) begin
                  state          <= TRAIN;
                  dfi_cke        <= 1'b1;
                  dfi_init_start <= 1'b1;
               end
            TRAIN:
               if (dfi_init_complete) begin
                  state          <= DONE;
                  dfi_init_start <= 1'b0;
                  init_done      <= 1'b1;
               end else if (timeout) begin
                  dfi_init_start <= 1'b0;
                  if (retry_ok) begin
                     state       <= RST_HOLD;
                     retry_cnt   <= retry_cnt + 4'd1;
                     dfi_reset_n <= 1'b0;
                     dfi_cke     <= 1'b0;
                  end else begin
                     state      <= ERROR;
                     init_error <= 1'b1;
                  end
               end
            DONE, ERROR:
               if (restart) begin
                  state          <= RST_HOLD;
                  dfi_reset_n    <= 1'b0;
                  dfi_cke        <= 1'b0;
                  dfi_init_start <= 1'b0;
                  init_done      <= 1'b0;
                  init_error     <= 1'b0;
                  retry_cnt      <= 4'd0;
               end
            default:
               state <= RST_HOLD;
         endcase
      end

endmodule

// File: tb/tb_dram_init_seq.sv
// tb_dram_init_seq: scoreboard bench for dram_init_seq; output changes are matched against queued expectations
`timescale 1ns/1ps
module tb_dram_init_seq;

   logic       clk_sys = 1'b0;
   logic       rst_sys_n = 1'b1;
   logic       restart = 1'b0;
   logic       dfi_init_complete = 1'b0;
   logic       dfi_reset_n;
   logic       dfi_cke;
   logic       dfi_init_start;
   logic       init_done;
   logic       init_error;
   logic [3:0] retry_cnt;
   logic [8:0] outv;
   logic [8:0] prev = '0;
   logic       mon_en = 1'b0;
   int         cyc = -1;
   int         checks = 0;
   int         errors = 0;
   int         mid_k;
   int         cq[$];
   logic [8:0] vq[$];
   string      nq[$];
   string      e_n;
   int         e_c;
   logic [8:0] e_v;

   dram_init_seq #(
      .RESET_CYCLES   (4),
      .CKE_CYCLES     (3),
      .TIMEOUT_CYCLES (10),
      .MAX_RETRIES    (2)
   ) dut (
      .clk_sys           (clk_sys),
      .rst_sys_n         (rst_sys_n),
      .restart           (restart),
      .dfi_init_complete (dfi_init_complete),
      .dfi_reset_n       (dfi_reset_n),
      .dfi_cke           (dfi_cke),
      .dfi_init_start    (dfi_init_start),
      .init_done         (init_done),
      .init_error        (init_error),
      .retry_cnt         (retry_cnt)
   );

   assign outv = {dfi_reset_n, dfi_cke, dfi_init_start, init_done, init_error, retry_cnt};

   always #5 clk_sys = ~clk_sys;

   // Cycle k is the interval after the k-th rising edge following reset release.
   always @(posedge clk_sys or negedge rst_sys_n)
      if (!rst_sys_n) cyc <= -1;
      else cyc <= cyc + 1;

   function automatic logic [8:0] ov(bit rn, bit ck, bit st, bit dn, bit er, int rc);
      return {rn, ck, st, dn, er, 4'(rc)};
   endfunction

   task automatic push(string n, int c, logic [8:0] v);
      nq.push_back(n);
      cq.push_back(c);
      vq.push_back(v);
   endtask

   task automatic chk(string n, logic [8:0] got, logic [8:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b want %b (cycle %0d)", n, got, exp, cyc);
      end
   endtask

   task automatic wait_cyc(int k);
      while (cyc < k) @(negedge clk_sys);
   endtask

   // Monitor: every change of the output vector must match the next queued expectation.
   always @(negedge clk_sys)
      if (mon_en && outv !== prev) begin
         checks++;
         if (cq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change: got %b at cycle %0d, nothing expected", outv, cyc);
         end else begin
            e_n = nq.pop_front();
            e_c = cq.pop_front();
            e_v = vq.pop_front();
            if (e_c != cyc || e_v !== outv) begin
               errors++;
               $display("FAIL %s: got %b at cycle %0d, want %b at cycle %0d", e_n, outv, cyc, e_v, e_c);
            end
         end
         prev = outv;
      end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      #1 rst_sys_n = 1'b0;
      mon_en = 1'b1;
      repeat (3) @(negedge clk_sys);
      chk("reset_state", outv, 9'd0);
      push("reset_n_rise", 4, ov(1, 0, 0, 0, 0, 0));
      push("train_start", 7, ov(1, 1, 1, 0, 0, 0));
      push("init_done", 13, ov(1, 1, 0, 1, 0, 0));
      push("restart_done", 17, ov(0, 0, 0, 0, 0, 0));
      push("restart_cke", 21, ov(1, 0, 0, 0, 0, 0));
      push("restart_train", 24, ov(1, 1, 1, 0, 0, 0));
      @(negedge clk_sys);
      rst_sys_n = 1'b1;
      wait_cyc(2);  dfi_init_complete = 1'b1;
      wait_cyc(3);  dfi_init_complete = 1'b0;
      wait_cyc(5);  dfi_init_complete = 1'b1;
      wait_cyc(6);  dfi_init_complete = 1'b0;
      wait_cyc(12); dfi_init_complete = 1'b1;
      wait_cyc(13); dfi_init_complete = 1'b0;
      wait_cyc(16); restart = 1'b1;
      wait_cyc(17); restart = 1'b0;
      wait_cyc(22); restart = 1'b1;
      wait_cyc(23); restart = 1'b0;
`ifdef DRAM_INIT_SEQ_TIMEOUT_EN
      push("retry1", 34, ov(0, 0, 0, 0, 0, 1));
      push("retry1_cke", 38, ov(1, 0, 0, 0, 0, 1));
      push("retry1_train", 41, ov(1, 1, 1, 0, 0, 1));
      push("retry2", 51, ov(0, 0, 0, 0, 0, 2));
      push("retry2_cke", 55, ov(1, 0, 0, 0, 0, 2));
      push("retry2_train", 58, ov(1, 1, 1, 0, 0, 2));
      push("error", 68, ov(1, 1, 0, 0, 1, 2));
      push("err_restart", 73, ov(0, 0, 0, 0, 0, 0));
      push("rs_cke", 77, ov(1, 0, 0, 0, 0, 0));
      push("rs_train", 80, ov(1, 1, 1, 0, 0, 0));
      push("rs_retry1", 90, ov(0, 0, 0, 0, 0, 1));
      push("rs_cke2", 94, ov(1, 0, 0, 0, 0, 1));
      push("rs_train2", 97, ov(1, 1, 1, 0, 0, 1));
      push("tie_done", 107, ov(1, 1, 0, 1, 0, 1));
      push("done_restart", 111, ov(0, 0, 0, 0, 0, 0));
      push("cke3", 115, ov(1, 0, 0, 0, 0, 0));
      push("train3", 118, ov(1, 1, 1, 0, 0, 0));
      wait_cyc(69);  chk("error_hold", outv, ov(1, 1, 0, 0, 1, 2));
      wait_cyc(70);  dfi_init_complete = 1'b1;
      wait_cyc(71);  dfi_init_complete = 1'b0;
      wait_cyc(72);  chk("error_ignores_complete", outv, ov(1, 1, 0, 0, 1, 2));
      restart = 1'b1;
      wait_cyc(73);  restart = 1'b0;
      wait_cyc(106); dfi_init_complete = 1'b1;
      wait_cyc(107); dfi_init_complete = 1'b0;
      wait_cyc(110); restart = 1'b1;
      wait_cyc(111); restart = 1'b0;
      mid_k = 120;
`else
      wait_cyc(1024);
      chk("train_hold", outv, ov(1, 1, 1, 0, 0, 0));
      mid_k = 1030;
`endif
      push("mid_reset", -1, ov(0, 0, 0, 0, 0, 0));
      wait_cyc(mid_k);
      #2 rst_sys_n = 1'b0;
      #1 chk("async_reset", outv, 9'd0);
      repeat (2) @(negedge clk_sys);
      push("post_reset", 4, ov(1, 0, 0, 0, 0, 0));
      rst_sys_n = 1'b1;
      wait_cyc(6);
      checks++;
      if (cq.size() != 0) begin
         errors++;
         $display("FAIL pending_expectations: got %0d outstanding want 0", cq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
